// File: rtl/ddc_edid_responder_if.sv
// EDID memory port between the DDC responder (master) and a 256x8 EDID store (slave).
// Read data is expected one clk after mem_addr changes.
interface ddc_edid_responder_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_wdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ddc_edid_responder.sv
// I2C target for the HDMI DDC channel: serves EDID bytes from an external 256x8 memory
// at a fixed 7-bit address, with optional writes. Never stretches SCL.
module ddc_edid_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 4,
  parameter bit         WRITE_EN   = 1'b0
) (
  input  logic                        clk,
  input  logic                        nReset,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oen,
  ddc_edid_responder_if.master        mem,
  output logic                        busy,
  output logic                        rd_byte
);

  localparam int            CW      = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    OFFS,
    OFFS_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through synchroniser and filter.
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    filt;
  logic [1:0]    filt_d;
  logic [CW-1:0] flt_cnt [2];

  state_t     state;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic [7:0] offset;
  logic       we_q;
  logic [7:0] wdata_q;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic       sda_bit;
  logic [7:0] byte_in;

  // A level change is accepted only after FILTER_LEN consecutive clks at the new level.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        flt_cnt[i] <= '0;
      end
    end else begin
      sync_a <= {sda_i, scl_i};
      sync_b <= sync_a;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CNT_MAX) begin
          filt[i]    <= sync_b[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign scl_rise   =  filt[0] & ~filt_d[0];
  assign scl_fall   = ~filt[0] &  filt_d[0];
  assign start_cond =  filt[0] &  filt_d[0] &  filt_d[1] & ~filt[1];
  assign stop_cond  =  filt[0] &  filt_d[0] & ~filt_d[1] &  filt[1];
  assign sda_bit    =  filt[1];
  assign byte_in    = {shift[6:0], sda_bit};

  // START/STOP override bit events; SDA only changes on scl_fall otherwise.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      offset  <= '0;
      sda_oen <= 1'b1;
      busy    <= 1'b0;
      rd_byte <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      rd_byte <= 1'b0;
      we_q    <= 1'b0;
      if (we_q) begin
        offset <= offset + 8'd1;
      end

      if (start_cond) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oen <= 1'b1;
      end else if (stop_cond) begin
        state   <= IDLE;
        sda_oen <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          ADDR, OFFS, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == OFFS) begin
                  offset <= byte_in;
                end
                if (state == WDATA && WRITE_EN) begin
                  we_q    <= 1'b1;
                  wdata_q <= byte_in;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (state == OFFS) begin
                sda_oen <= 1'b0;
                state   <= OFFS_ACK;
              end else if (state == WDATA) begin
                sda_oen <= 1'b0;
                state   <= WDATA_ACK;
              end else if (shift[7:1] == DEV_ADDR) begin
                sda_oen <= 1'b0;
                busy    <= 1'b1;
                state   <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (shift[0]) begin
                shift   <= mem.mem_rdata;
                sda_oen <= mem.mem_rdata[7];
                state   <= RDATA;
              end else begin
                sda_oen <= 1'b1;
                state   <= OFFS;
              end
            end
          end

          OFFS_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_oen <= 1'b1;
              bit_cnt <= '0;
              state   <= (state == OFFS_ACK) ? WDATA : state;
              if (state == WDATA_ACK) begin
                state <= WDATA;
              end
            end
          end

          // Bit 7 was driven on entry; the remaining seven go out MSB first.
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oen <= 1'b1;
                state   <= RACK;
              end else begin
                sda_oen <= shift[6];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          RACK: begin
            if (scl_rise) begin
              rd_byte <= 1'b1;
              offset  <= offset + 8'd1;
              if (sda_bit) begin
                state <= IDLE;
              end
            end else if (scl_fall) begin
              shift   <= mem.mem_rdata;
              sda_oen <= mem.mem_rdata[7];
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end

          default: begin
            state   <= IDLE;
            sda_oen <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mem.mem_addr  = offset;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_ddc_edid_responder.sv
// Directed bench: a bit-banged DDC host drives two responders (read-only and write-enabled),
// each on its own wired-AND SDA line, backed by a 256x8 memory model with 1-clk read latency.
`timescale 1ns/1ps
module tb_ddc_edid_responder;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic scl = 1'b1;
  logic sda_drv = 1'b1;
  logic oen0, oen1, busy0, busy1, rd_byte0, rd_byte1;
  logic sda0, sda1;

  int vectors = 0;
  int miscompares = 0;

  int rd_cnt0 = 0;
  int we_cnt0 = 0;
  int we_cnt1 = 0;
  int low_cnt0 = 0;
  int busy_cnt0 = 0;
  logic [7:0] log_addr [16];
  logic [7:0] log_data [16];

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       init_done = 1'b0;

  ddc_edid_responder_if mif0 ();
  ddc_edid_responder_if mif1 ();

  assign sda0 = sda_drv & oen0;
  assign sda1 = sda_drv & oen1;

  always #5 clk = ~clk;

  ddc_edid_responder #(.DEV_ADDR(7'h50), .FILTER_LEN(4), .WRITE_EN(1'b0)) dut0 (
    .clk(clk), .nReset(nReset), .scl_i(scl), .sda_i(sda0), .sda_oen(oen0),
    .mem(mif0), .busy(busy0), .rd_byte(rd_byte0)
  );

  ddc_edid_responder #(.DEV_ADDR(7'h50), .FILTER_LEN(4), .WRITE_EN(1'b1)) dut1 (
    .clk(clk), .nReset(nReset), .scl_i(scl), .sda_i(sda1), .sda_oen(oen1),
    .mem(mif1), .busy(busy1), .rd_byte(rd_byte1)
  );

  function automatic logic [7:0] edid(input logic [7:0] a);
    return a * 8'd7 + 8'd3;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= edid(8'(i));
        mem1[i] <= edid(8'(i));
      end
      init_done <= 1'b1;
    end else begin
      mif0.mem_rdata <= mem0[mif0.mem_addr];
      mif1.mem_rdata <= mem1[mif1.mem_addr];
      if (mif0.mem_we) mem0[mif0.mem_addr] <= mif0.mem_wdata;
      if (mif1.mem_we) mem1[mif1.mem_addr] <= mif1.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (rd_byte0) rd_cnt0 <= rd_cnt0 + 1;
    if (mif0.mem_we) we_cnt0 <= we_cnt0 + 1;
    if (!oen0) low_cnt0 <= low_cnt0 + 1;
    if (busy0) busy_cnt0 <= busy_cnt0 + 1;
    if (mif1.mem_we) begin
      if (we_cnt1 < 16) begin
        log_addr[we_cnt1] <= mif1.mem_addr;
        log_data[we_cnt1] <= mif1.mem_wdata;
      end
      we_cnt1 <= we_cnt1 + 1;
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 800us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wait_clks(Q);
    scl = 1'b1;     wait_clks(Q);
    sda_drv = 1'b0; wait_clks(Q);
    scl = 1'b0;     wait_clks(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wait_clks(Q);
    scl = 1'b1;     wait_clks(Q);
    sda_drv = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    sda_drv = b;
    wait_clks(Q);
    scl = 1'b1;
    if (glitch) begin
      wait_clks(8);
      scl = 1'b0;
      wait_clks(2);
      scl = 1'b1;
      wait_clks(10);
    end else begin
      wait_clks(2 * Q);
    end
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic read_bit(output logic b0, output logic b1);
    sda_drv = 1'b1; wait_clks(Q);
    scl = 1'b1;     wait_clks(Q);
    b0 = sda0;
    b1 = sda1;
    wait_clks(Q);
    scl = 1'b0;     wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit,
                            output logic ack0, output logic ack1);
    logic x0, x1;
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(x0, x1);
    ack0 = ~x0;
    ack1 = ~x1;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] d0, output logic [7:0] d1);
    logic b0, b1;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b0, b1);
      d0[i] = b0;
      d1[i] = b1;
    end
    write_bit(~ack, 1'b0);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    wait_clks(3);
    vectors += 6;
    if (oen0 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_oen: got %b expected 1", oen0); end
    if (mif0.mem_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_addr: got %h expected 00", mif0.mem_addr); end
    if (mif0.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b expected 0", mif0.mem_we); end
    if (mif0.mem_wdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h expected 00", mif0.mem_wdata); end
    if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
    if (rd_byte0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdbyte: got %b expected 0", rd_byte0); end
    nReset = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_offset_read();
    logic a0, a1;
    logic [7:0] d0, d1;
    logic [7:0] exp_d [3];
    int rd_base;
    exp_d[0] = 8'h73; exp_d[1] = 8'h7A; exp_d[2] = 8'h81;
    rd_base = rd_cnt0;
    bus_start();
    write_byte(8'hA0, -1, a0, a1);
    vectors++; if (a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ack_A0: got %b expected 1", a0); end
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_busy_on: got %b expected 1", busy0); end
    write_byte(8'h10, -1, a0, a1);
    vectors++; if (a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ack_off: got %b expected 1", a0); end
    bus_start();
    write_byte(8'hA1, -1, a0, a1);
    vectors++; if (a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ack_A1: got %b expected 1", a0); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i != 2, d0, d1);
      vectors++;
      if (d0 !== exp_d[i]) begin miscompares++; $display("[TB] FAIL rd_data%0d: got %h expected %h", i, d0, exp_d[i]); end
    end
    bus_stop();
    wait_clks(10);
    vectors++; if (rd_cnt0 - rd_base !== 3) begin miscompares++; $display("[TB] FAIL rd_pulses: got %0d expected 3", rd_cnt0 - rd_base); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_busy_off: got %b expected 0", busy0); end
    vectors++; if (mif0.mem_addr !== 8'h13) begin miscompares++; $display("[TB] FAIL rd_addr_end: got %h expected 13", mif0.mem_addr); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int low_base, busy_base;
    low_base = low_cnt0;
    busy_base = busy_cnt0;
    bus_start();
    write_byte(8'hA4, -1, a0, a1);
    vectors++; if (a0 !== 1'b0) begin miscompares++; $display("[TB] FAIL wa_ack: got %b expected 0", a0); end
    write_byte(8'h00, -1, a0, a1);
    bus_stop();
    wait_clks(10);
    vectors++; if (low_cnt0 - low_base !== 0) begin miscompares++; $display("[TB] FAIL wa_sda_low: got %0d clks expected 0", low_cnt0 - low_base); end
    vectors++; if (busy_cnt0 - busy_base !== 0) begin miscompares++; $display("[TB] FAIL wa_busy: got %0d clks expected 0", busy_cnt0 - busy_base); end
    vectors++; if (mif0.mem_addr !== 8'h13) begin miscompares++; $display("[TB] FAIL wa_addr: got %h expected 13", mif0.mem_addr); end
  endtask

  task automatic test_wrap();
    logic a0, a1;
    logic [7:0] d0, d1;
    bus_start();
    write_byte(8'hA0, -1, a0, a1);
    write_byte(8'hFF, -1, a0, a1);
    vectors++; if (a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_ack_off: got %b expected 1", a0); end
    bus_start();
    write_byte(8'hA1, -1, a0, a1);
    read_byte(1'b1, d0, d1);
    vectors++; if (d0 !== 8'hFC) begin miscompares++; $display("[TB] FAIL wrap_dFF: got %h expected FC", d0); end
    read_byte(1'b0, d0, d1);
    vectors++; if (d0 !== 8'h03) begin miscompares++; $display("[TB] FAIL wrap_d00: got %h expected 03", d0); end
    bus_stop();
    wait_clks(10);
    vectors++; if (mif0.mem_addr !== 8'h01) begin miscompares++; $display("[TB] FAIL wrap_addr: got %h expected 01", mif0.mem_addr); end
  endtask

  task automatic test_write();
    logic a0, a1;
    logic [7:0] wbytes [4];
    int base0, base1;
    wbytes[0] = 8'hA0; wbytes[1] = 8'h20; wbytes[2] = 8'h5A; wbytes[3] = 8'hC3;
    base0 = we_cnt0;
    base1 = we_cnt1;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(wbytes[i], -1, a0, a1);
      vectors++;
      if ({a0, a1} !== 2'b11) begin miscompares++; $display("[TB] FAIL wr_ack%0d: got %b expected 11", i, {a0, a1}); end
    end
    bus_stop();
    wait_clks(10);
    vectors++; if (we_cnt1 - base1 !== 2) begin miscompares++; $display("[TB] FAIL wr_we_count: got %0d expected 2", we_cnt1 - base1); end
    vectors++; if ({log_addr[base1], log_data[base1]} !== 16'h205A) begin miscompares++; $display("[TB] FAIL wr_first: got %h expected 205A", {log_addr[base1], log_data[base1]}); end
    vectors++; if ({log_addr[base1+1], log_data[base1+1]} !== 16'h21C3) begin miscompares++; $display("[TB] FAIL wr_second: got %h expected 21C3", {log_addr[base1+1], log_data[base1+1]}); end
    vectors++; if (mif1.mem_addr !== 8'h22) begin miscompares++; $display("[TB] FAIL wr_addr_we1: got %h expected 22", mif1.mem_addr); end
    vectors++; if (we_cnt0 - base0 !== 0) begin miscompares++; $display("[TB] FAIL wr_we_ro: got %0d expected 0", we_cnt0 - base0); end
    vectors++; if (mif0.mem_addr !== 8'h20) begin miscompares++; $display("[TB] FAIL wr_addr_ro: got %h expected 20", mif0.mem_addr); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1;
    logic [7:0] d0, d1;
    bus_start();
    write_byte(8'hA0, -1, a0, a1);
    write_byte(8'h20, -1, a0, a1);
    bus_start();
    write_byte(8'hA1, -1, a0, a1);
    vectors++; if ({a0, a1} !== 2'b11) begin miscompares++; $display("[TB] FAIL b2b_ack: got %b expected 11", {a0, a1}); end
    read_byte(1'b1, d0, d1);
    vectors++; if ({d0, d1} !== 16'hE35A) begin miscompares++; $display("[TB] FAIL b2b_byte0: got %h expected E35A", {d0, d1}); end
    read_byte(1'b0, d0, d1);
    vectors++; if ({d0, d1} !== 16'hEAC3) begin miscompares++; $display("[TB] FAIL b2b_byte1: got %h expected EAC3", {d0, d1}); end
    bus_stop();
    wait_clks(10);
  endtask

  task automatic test_glitch();
    logic a0, a1;
    logic [7:0] d0, d1;
    bus_start();
    write_byte(8'hA0, 4, a0, a1);
    vectors++; if (a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL gl_ack_addr: got %b expected 1", a0); end
    write_byte(8'h40, 2, a0, a1);
    vectors++; if (a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL gl_ack_off: got %b expected 1", a0); end
    bus_start();
    write_byte(8'hA1, -1, a0, a1);
    read_byte(1'b0, d0, d1);
    vectors++; if (d0 !== 8'hC3) begin miscompares++; $display("[TB] FAIL gl_data: got %h expected C3", d0); end
    bus_stop();
    wait_clks(10);
    vectors++; if (mif0.mem_addr !== 8'h41) begin miscompares++; $display("[TB] FAIL gl_addr: got %h expected 41", mif0.mem_addr); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    bus_start();
    write_byte(8'hA0, -1, a0, a1);
    write_byte(8'h00, -1, a0, a1);
    bus_start();
    write_byte(8'hA1, -1, a0, a1);
    vectors++; if (oen0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_driving: got %b expected 0", oen0); end
    nReset = 1'b0;
    #1;
    vectors++; if (oen0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_release: got %b expected 1", oen0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy: got %b expected 0", busy0); end
    wait_clks(5);
    nReset = 1'b1;
    wait_clks(10);
    bus_stop();
    wait_clks(10);
  endtask

  initial begin
    $display("[TB] start");
    wait_clks(2);
    test_reset();
    test_offset_read();
    test_wrong_addr();
    test_wrap();
    test_write();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_offset_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
